// File: rtl/pong_text_pkg.sv
// Character codes and menu state encoding shared by the text renderers.
package pong_text_pkg;

    localparam logic [6:0] CH_BLANK  = 7'h20;
    localparam logic [6:0] CH_EXCL   = 7'h21;
    localparam logic [6:0] CH_DASH   = 7'h2D;
    localparam logic [6:0] CH_PERIOD = 7'h2E;
    localparam logic [6:0] CH_COLON  = 7'h3A;
    localparam logic [6:0] CH_GT     = 7'h3E;

    localparam logic [6:0] ZERO  = 7'h30, ONE   = 7'h31, TWO   = 7'h32, THREE = 7'h33;
    localparam logic [6:0] FOUR  = 7'h34, FIVE  = 7'h35, SIX   = 7'h36, SEVEN = 7'h37;
    localparam logic [6:0] EIGHT = 7'h38, NINE  = 7'h39;

    localparam logic [6:0] CAP_A = 7'h41, CAP_B = 7'h42, CAP_C = 7'h43, CAP_D = 7'h44;
    localparam logic [6:0] CAP_E = 7'h45, CAP_F = 7'h46, CAP_G = 7'h47, CAP_H = 7'h48;
    localparam logic [6:0] CAP_I = 7'h49, CAP_J = 7'h4A, CAP_K = 7'h4B, CAP_L = 7'h4C;
    localparam logic [6:0] CAP_M = 7'h4D, CAP_N = 7'h4E, CAP_O = 7'h4F, CAP_P = 7'h50;
    localparam logic [6:0] CAP_Q = 7'h51, CAP_R = 7'h52, CAP_S = 7'h53, CAP_T = 7'h54;
    localparam logic [6:0] CAP_U = 7'h55, CAP_V = 7'h56, CAP_W = 7'h57, CAP_X = 7'h58;
    localparam logic [6:0] CAP_Y = 7'h59, CAP_Z = 7'h5A;

    localparam logic [0:0] ST_BROWSE = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    function automatic logic [6:0] mode_word_char(input int idx);
        case (idx)
            0:       return CAP_M;
            1:       return CAP_O;
            2:       return CAP_D;
            3:       return CAP_E;
            default: return CH_BLANK;
        endcase
    endfunction

    function automatic logic [6:0] select_word_char(input int idx);
        case (idx)
            0:       return CAP_S;
            1:       return CAP_E;
            2:       return CAP_L;
            3:       return CAP_E;
            4:       return CAP_C;
            5:       return CAP_T;
            default: return CH_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/menu_blink_timer.sv
// Cursor blink: counts frame ticks and toggles blink_on every BLINK_FRAMES ticks.
module menu_blink_timer #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic reset_n,
    input  logic frame_tick,
    input  logic clear,
    input  logic freeze,
    output logic blink_on
);
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_blink_on;

    // clear wins over a same-cycle frame tick so a moved cursor shows at once
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_blink_on <= 1'b1;
        end else if (clear) begin
            r_cnt      <= '0;
            r_blink_on <= 1'b1;
        end else if (frame_tick && !freeze) begin
            if (r_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                r_cnt      <= '0;
                r_blink_on <= ~r_blink_on;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign blink_on = r_blink_on;

endmodule

// File: rtl/mode_select_menu.sv
// Mode-selection menu: title row plus one row per mode, blinking cursor,
// browse/lock selection FSM. state | meaning: BROWSE = cursor moves, LOCKED = mode confirmed.
module mode_select_menu
    import pong_text_pkg::*;
#(
    parameter int COLS         = 16,
    parameter int COL_W        = 4,
    parameter int ROW_W        = 4,
    parameter int NUM_MODES    = 4,
    parameter int MODE_W       = 2,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [ROW_W+COL_W-1:0] char_xy,
    input  logic                   frame_tick,
    input  logic                   btn_up,
    input  logic                   btn_down,
    input  logic                   btn_sel,
    input  logic                   restart,
    output logic [6:0]             char_code,
    output logic [MODE_W-1:0]      mode,
    output logic                   mode_done,
    output logic                   menu_active
);
    logic [0:0]        r_state;
    logic [MODE_W-1:0] r_sel;
    logic [MODE_W-1:0] r_mode;
    logic              r_mode_done;
    logic [6:0]        r_char_code;

    logic              w_blink_on;
    logic              w_browse_idle;
    logic              w_move_up;
    logic              w_move_down;
    logic [6:0]        w_code;
    int                w_row_i;
    int                w_col_i;
    int                w_sel_i;

    assign w_browse_idle = (r_state == ST_BROWSE) && !restart && !btn_sel;
    assign w_move_up     = w_browse_idle && btn_up && !btn_down && (NUM_MODES > 1);
    assign w_move_down   = w_browse_idle && btn_down && !btn_up && (NUM_MODES > 1);

    menu_blink_timer #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .clk       (clk),
        .reset_n   (reset_n),
        .frame_tick(frame_tick),
        .clear     (w_move_up || w_move_down),
        .freeze    (r_state == ST_LOCKED),
        .blink_on  (w_blink_on)
    );

    assign w_row_i = int'(char_xy[ROW_W+COL_W-1:COL_W]);
    assign w_col_i = int'(char_xy[COL_W-1:0]);
    assign w_sel_i = int'(r_sel);

    always_comb begin
        w_code = CH_BLANK;
        if (w_col_i < COLS) begin
            if (w_row_i == 0) begin
                if (w_col_i < 4)
                    w_code = mode_word_char(w_col_i);
                else if (w_col_i >= COLS - 6)
                    w_code = select_word_char(w_col_i - (COLS - 6));
            end else if (w_row_i <= NUM_MODES) begin
                if (w_col_i == 0) begin
                    if ((w_row_i - 1 == w_sel_i) && (w_blink_on || r_state == ST_LOCKED))
                        w_code = CH_GT;
                end else if (w_col_i >= 2 && w_col_i <= 5) begin
                    w_code = mode_word_char(w_col_i - 2);
                end else if (w_col_i == 7) begin
                    w_code = ZERO + 7'(w_row_i);
                end
            end
        end
    end

    // restart outranks a same-cycle btn_sel; btn_sel outranks moves
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_BROWSE;
            r_sel       <= '0;
            r_mode      <= '0;
            r_mode_done <= 1'b0;
            r_char_code <= CH_BLANK;
        end else begin
            r_mode_done <= 1'b0;
            r_char_code <= w_code;
            if (restart) begin
                r_state <= ST_BROWSE;
            end else if (r_state == ST_BROWSE) begin
                if (btn_sel) begin
                    r_state     <= ST_LOCKED;
                    r_mode      <= r_sel;
                    r_mode_done <= 1'b1;
                end else if (w_move_up) begin
                    r_sel <= (r_sel == '0) ? MODE_W'(NUM_MODES - 1) : r_sel - MODE_W'(1);
                end else if (w_move_down) begin
                    r_sel <= (r_sel == MODE_W'(NUM_MODES - 1)) ? '0 : r_sel + MODE_W'(1);
                end
            end
        end
    end

    assign char_code   = r_char_code;
    assign mode        = r_mode;
    assign mode_done   = r_mode_done;
    assign menu_active = (r_state == ST_BROWSE);

endmodule

// File: tb/tb_mode_select_menu.sv
// Directed bench for mode_select_menu with default parameters.
module tb_mode_select_menu;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] char_xy;
    logic       frame_tick, btn_up, btn_down, btn_sel, restart;
    logic [6:0] char_code;
    logic [1:0] mode;
    logic       mode_done, menu_active;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] xy;
        logic [6:0] exp;
        string      name;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mode_select_menu dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .char_xy    (char_xy),
        .frame_tick (frame_tick),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_sel    (btn_sel),
        .restart    (restart),
        .char_code  (char_code),
        .mode       (mode),
        .mode_done  (mode_done),
        .menu_active(menu_active)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [7:0] xy, input logic [6:0] exp, input string name);
        vec_t v;
        v.xy = xy;
        v.exp = exp;
        v.name = name;
        vecs.push_back(v);
    endtask

    task automatic read_cell(input int row, input int col, input logic [6:0] exp, input string name);
        char_xy = {4'(row), 4'(col)};
        tick();
        check(name, 32'(char_code), 32'(exp));
    endtask

    task automatic pulse(input logic u, input logic d, input logic s, input logic r, input logic f);
        btn_up = u; btn_down = d; btn_sel = s; restart = r; frame_tick = f;
        tick();
        btn_up = 0; btn_down = 0; btn_sel = 0; restart = 0; frame_tick = 0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) pulse(0, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        reset_n = 0;
        tick();
        reset_n = 1;
    endtask

    initial begin
        string hdr;
        reset_n = 0; char_xy = 8'h00; frame_tick = 0;
        btn_up = 0; btn_down = 0; btn_sel = 0; restart = 0;

        hdr = "MODE      SELECT";
        for (int i = 0; i < 16; i++)
            add_vec({4'd0, 4'(i)}, 7'(hdr[i]), $sformatf("row0_col%0d", i));
        add_vec(8'h10, 7'h3E, "row1_cursor");
        add_vec(8'h11, 7'h20, "row1_col1");
        add_vec(8'h12, 7'h4D, "row1_M");
        add_vec(8'h13, 7'h4F, "row1_O");
        add_vec(8'h14, 7'h44, "row1_D");
        add_vec(8'h15, 7'h45, "row1_E");
        add_vec(8'h16, 7'h20, "row1_col6");
        add_vec(8'h17, 7'h31, "row1_digit");
        add_vec(8'h18, 7'h20, "row1_col8");
        add_vec(8'h20, 7'h20, "row2_nocursor");
        add_vec(8'h47, 7'h34, "row4_digit");
        add_vec(8'h50, 7'h20, "row5_col0");
        add_vec(8'h57, 7'h20, "row5_col7");
        add_vec(8'h53, 7'h20, "row5_col3");
        add_vec(8'hF7, 7'h20, "row15_col7");

        // reset state
        tick(); tick();
        check("rst_char_code", 32'(char_code), 32'h20);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_mode_done", 32'(mode_done), 32'd0);
        check("rst_menu_active", 32'(menu_active), 32'd1);
        reset_n = 1;

        foreach (vecs[i]) begin
            char_xy = vecs[i].xy;
            tick();
            check(vecs[i].name, 32'(char_code), 32'(vecs[i].exp));
        end
        check("t1_menu_active", 32'(menu_active), 32'd1);

        // blink over 60 frame ticks
        for (int k = 0; k < 60; k++) begin
            read_cell(1, 0, (k < 30) ? 7'h3E : 7'h20, $sformatf("blink_tick%0d", k));
            pulse(0, 0, 0, 0, 1);
        end

        // cursor moves
        frames(30);
        read_cell(1, 0, 7'h20, "t3_blink_off");
        pulse(1, 0, 0, 0, 0);
        read_cell(4, 0, 7'h3E, "t3_up_wrap_row4");
        read_cell(1, 0, 7'h20, "t3_up_row1_clear");
        frames(29);
        read_cell(4, 0, 7'h3E, "t3_cnt_cleared_29");
        frames(1);
        read_cell(4, 0, 7'h20, "t3_cnt_cleared_30");
        for (int i = 0; i < 4; i++) pulse(0, 1, 0, 0, 0);
        read_cell(4, 0, 7'h3E, "t3_down4_row4");
        read_cell(1, 0, 7'h20, "t3_down4_row1");
        pulse(1, 1, 0, 0, 0);
        read_cell(4, 0, 7'h3E, "t3_updown_row4");
        read_cell(3, 0, 7'h20, "t3_updown_row3");

        // confirm selection
        do_reset();
        pulse(0, 1, 0, 0, 0);
        pulse(0, 1, 0, 0, 0);
        pulse(0, 0, 1, 0, 0);
        check("t4_mode_done_hi", 32'(mode_done), 32'd1);
        check("t4_mode", 32'(mode), 32'd2);
        check("t4_menu_active", 32'(menu_active), 32'd0);
        tick();
        check("t4_mode_done_lo", 32'(mode_done), 32'd0);
        pulse(1, 0, 0, 0, 0);
        pulse(0, 1, 0, 0, 0);
        read_cell(3, 0, 7'h3E, "t4_locked_row3");
        read_cell(2, 0, 7'h20, "t4_locked_row2");
        frames(30);
        read_cell(3, 0, 7'h3E, "t4_locked_steady");

        // restart beats btn_sel
        pulse(0, 0, 1, 1, 0);
        check("t5_menu_active", 32'(menu_active), 32'd1);
        check("t5_no_done", 32'(mode_done), 32'd0);
        check("t5_mode_kept", 32'(mode), 32'd2);
        tick();
        check("t5_no_done_late", 32'(mode_done), 32'd0);
        read_cell(3, 0, 7'h3E, "t5_sel_kept");
        pulse(1, 0, 0, 0, 0);
        pulse(0, 0, 1, 0, 0);
        check("t5_reselect_mode", 32'(mode), 32'd1);
        check("t5_reselect_done", 32'(mode_done), 32'd1);

        // reset while locked with sel=3
        pulse(0, 0, 0, 1, 0);
        pulse(0, 1, 0, 0, 0);
        pulse(0, 1, 0, 0, 0);
        pulse(0, 0, 1, 0, 0);
        check("t6_pre_mode", 32'(mode), 32'd3);
        char_xy = 8'h40;
        reset_n = 0;
        tick();
        check("t6_rst_char", 32'(char_code), 32'h20);
        check("t6_rst_mode", 32'(mode), 32'd0);
        check("t6_rst_active", 32'(menu_active), 32'd1);
        check("t6_rst_done", 32'(mode_done), 32'd0);
        reset_n = 1;
        read_cell(1, 0, 7'h3E, "t6_sel0_row1");
        read_cell(4, 0, 7'h20, "t6_sel0_row4");

        // move and frame tick together: move wins
        frames(29);
        pulse(0, 1, 0, 0, 1);
        read_cell(2, 0, 7'h3E, "t7_move_tick_row2");
        frames(29);
        read_cell(2, 0, 7'h3E, "t7_move_tick_cnt");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mode_select_menu.md
# mode_select_menu

Parametrised, clocked successor to the fixed 16×1 "MODE SELECT" text row. It renders a multi-row mode-selection menu: a title row followed by one row per selectable mode, with a blinking cursor. It owns the selection state machine driven by debounced button pulses and reports the chosen mode to the game controller. It sits between the VGA character-address generator, which supplies `char_xy`, and the font ROM, which consumes `char_code`.

## Interface
- `COLS`, 16: visible characters per row, 8..2^COL_W.
- `COL_W`, 4: column field width in `char_xy`.
- `ROW_W`, 4: row field width in `char_xy`.
- `NUM_MODES`, 4: selectable modes, 1..9, NUM_MODES+1 ≤ 2^ROW_W.
- `MODE_W`, 2: width of `mode`, ≥ clog2(NUM_MODES).
- `BLINK_FRAMES`, 30: frame ticks per cursor blink half-period, ≥1.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `char_xy`  in  ROW_W+COL_W  character address: {row, col}, with row in the upper field.
- `frame_tick`  in  1  one-cycle pulse per video frame.
- `btn_up`  in  1  one-cycle pulse that moves the cursor up.
- `btn_down`  in  1  one-cycle pulse that moves the cursor down.
- `btn_sel`  in  1  one-cycle pulse that confirms the current selection.
- `restart`  in  1  level that returns the menu to browsing.
- `char_code`  out  7  ASCII code for `char_xy`, registered.
- `mode`  out  MODE_W  confirmed mode index, 0-based.
- `mode_done`  out  1  one-cycle pulse on confirmation.
- `menu_active`  out  1  high while in the BROWSE state.

## Operation
**Text layout.** Character codes are taken from the shared package.
- Row 0: "MODE" in cols 0–3 and "SELECT" in cols COLS-6..COLS-1. All other columns are BLANK (0x20).
- Row r, for 1 ≤ r ≤ NUM_MODES:
  - col 0 is the cursor.
  - cols 2–5 hold "MODE".
  - col 7 holds the digit `'0'+r`.
  - all other columns are BLANK.
- Cursor: '>' (0x3E) when r-1 = `sel` and either `blink_on` is high or the state is LOCKED. Otherwise the cursor cell is BLANK.
- Rows > NUM_MODES, or cols ≥ COLS: BLANK.

**State machine.** Two states, BROWSE and LOCKED. Reset state: BROWSE, with `sel`=0.
- BROWSE, `btn_up`: `sel` decrements; 0 wraps to NUM_MODES-1.
- BROWSE, `btn_down`: `sel` increments; NUM_MODES-1 wraps to 0.
- BROWSE, `btn_up` and `btn_down` in the same cycle: no movement.
- BROWSE, `btn_sel`: go to LOCKED, set `mode`←`sel`, and pulse `mode_done` for one cycle. `btn_sel` has priority over up/down in the same cycle; the move is discarded.
- LOCKED: up/down/sel are ignored and the cursor is steady.
- `restart` high: go to BROWSE next cycle, keeping `sel` and `mode`. `restart` beats `btn_sel` when both are asserted in the same cycle.
- NUM_MODES=1: up/down leave `sel` at 0.

**Blink.**
- Counter of `frame_tick` pulses, range 0..BLINK_FRAMES-1.
- On wrap, `blink_on` toggles.
- Any accepted cursor move clears the counter and sets `blink_on`=1, so the cursor shows immediately.
- Entering LOCKED freezes the counter.

## Timing
- `char_code`: registered, 1-cycle latency. The value at cycle t+1 reflects `char_xy` and the state (`sel`, `blink_on`, FSM) at cycle t.
- A button pulse at edge t updates `sel` at t+1. The cursor change appears in `char_code` at t+2.
- `mode_done`: asserted exactly in the cycle after the accepted `btn_sel`, never for two cycles.
- Reset values (while `reset_n`=0 at a rising edge):
  - `char_code`=0x20, `mode`=0, `mode_done`=0, `menu_active`=1.
  - `sel`=0, `blink_on`=1, blink counter 0.
- Reset mid-operation, including in LOCKED, discards everything above.
- `frame_tick` and button pulses in the same cycle are processed independently. A move in that cycle overrides the blink toggle.

## Structure
- Shared package `pong_text_pkg` holds:
  - the 7-bit character constants: BLANK, '>', digits ZERO–NINE, CAP_A–CAP_Z, punctuation;
  - the FSM state enumeration for BROWSE and LOCKED.
- Sub-module `menu_blink_timer` contains the frame counter and `blink_on`, with inputs `clear` and `freeze`.
- The text decode stays inline, as a combinational lookup followed by the output register.

## Test plan
1. Reset, then sweep row 0 with COLS=16 → `char_code` (1 cycle later) = M,O,D,E, six BLANKs, S,E,L,E,C,T. `menu_active`=1.
2. Read row 1 col 0 across 60 `frame_tick`s with BLINK_FRAMES=30 → 0x3E for the first 30 ticks, 0x20 for the next 30. Row 1 col 7 = 0x31. Row 5 is all 0x20.
3. `btn_up` from `sel`=0 with NUM_MODES=4 → cursor on row 4, `blink_on`=1. Four `btn_down` pulses → back to row 4. Simultaneous up+down → no change.
4. `btn_down` twice, then `btn_sel` → `mode`=2, `mode_done` high for exactly one cycle, `menu_active`=0. Later up/down pulses leave the cursor steady on row 3.
5. `restart` asserted in the same cycle as `btn_sel` while in LOCKED → BROWSE, no `mode_done` pulse, `mode` unchanged.
6. `reset_n`=0 for one edge while in LOCKED with `sel`=3 → `char_code`=0x20, `mode`=0, `sel`=0, `menu_active`=1 on the next cycle.
